sp_if_in_ddr_rx: RTL and testbench
==================================

// Module: sp_if_in_ddr_rx
// PURPOSE
//  Receive side of the SP-IF DDR3 Avalon-ST path: accepts 128-bit read-data packets returned from DDR3,
//  buffers them in an internal beat RAM, then unpacks each beat into 32-bit words for the signal processor.
//  Sits between the DDR3 read streaming port and the SP input stage; one packet per i_ddr_rd_startp.
// PARAMETERS
//  RAM_AW   11    beat RAM address width; capacity 2**RAM_AW beats of 128 bits (2048 x 16 byte)
// PORTS
//  i_clk156m      in   1    system clock 156.25MHz
//  i_arst         in   1    reset, synchronous, active-high
//  i_ddr_rd_startp in  1    transfer start pulse (1 cycle)
//  i_ddr_size     in   32   transfer size in bytes, sampled on i_ddr_rd_startp
//  i_rd_sop       in   1    Avalon-ST start of packet
//  i_rd_eop       in   1    Avalon-ST end of packet
//  i_rd_valid     in   1    Avalon-ST beat valid
//  i_rd_data      in   128  Avalon-ST beat data
//  o_rd_ready     out  1    Avalon-ST ready (0-cycle ready latency)
//  o_sp_data      out  32   unpacked word to SP
//  o_sp_valid     out  1    o_sp_data valid
//  i_sp_ready     in   1    SP accepts word
//  o_sp_done      out  1    1-cycle pulse after last word accepted
//  o_err_len      out  1    1-cycle pulse on length/protocol error
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, beat counters/RAM pointers 0. RAM contents not cleared.
//  Target beats T = i_ddr_size[31:4] (sub-16-byte remainder ignored). T==0 -> o_err_len pulse, stay IDLE.
//  T > 2**RAM_AW -> clamp T to 2**RAM_AW, o_err_len pulse, continue.
//  FSM IDLE: o_rd_ready=0. On i_ddr_rd_startp (T>0) -> WAIT_SOP next cycle, beat count N=0.
//  WAIT_SOP: o_rd_ready=1; beats with valid&!sop discarded (no RAM write, o_err_len pulse each).
//   valid&sop accepted as beat 0 -> RECV (if also eop or T==1 -> handled as last beat, see below).
//  RECV: o_rd_ready=1; each valid&ready beat written to RAM[N], N<=N+1.
//   Last beat = eop OR N==T-1. eop at N==T-1: normal. eop with N<T-1: early, o_err_len pulse.
//   N==T-1 without eop: o_err_len pulse. Either way -> UNPACK with B=N+1 stored beats; o_rd_ready=0 next cycle.
//   sop in RECV (not beat 0): o_err_len pulse, beat still written.
//  UNPACK: RAM read addr 0..B-1, 1-cycle RAM read latency, 2-entry skid so reads continue under ready.
//   Each beat emits 4 words; default order [31:0],[63:32],[95:64],[127:96].
//   o_sp_data/o_sp_valid held stable until i_sp_ready; word transfer = o_sp_valid&i_sp_ready.
//   i_sp_ready=1 continuously -> one word/cycle; first o_sp_valid 2 cycles after UNPACK entry.
//   After word 4B-1 accepted -> o_sp_done pulse next cycle, FSM -> IDLE.
//  i_ddr_rd_startp in any non-IDLE state: abort; o_sp_valid drops next cycle, counters/skid cleared,
//   no o_sp_done, restart at WAIT_SOP with new T. Beats in flight that cycle are discarded.
//  Simultaneous startp and last beat: startp wins (beat discarded).
//  Counters 32-bit compares; RAM address = N[RAM_AW-1:0]; no wrap possible after clamp.
//  i_arst mid-operation: immediate return to reset state on the next edge.
// CONFIGURATION
//  SP_IF_IN_WORD_SWAP_EN defined: word order per beat reversed ([127:96] first ... [31:0] last).
//  Not defined: lowest word [31:0] first. No other behaviour changes.
// TESTING
//  size=64, 4 beats sop..eop, sp_ready=1 -> 16 words in order, o_sp_done once, o_err_len never.
//  size=64, i_sp_ready toggles 1/0 each cycle -> no word lost/duplicated, data stable while ready=0.
//  size=128, eop on beat 3 -> o_err_len pulse, exactly 16 words output, o_sp_done.
//  size=48, 2 beats no sop then sop beat+2 -> 2 err pulses, 3 beats stored, 12 words from sop beat on.
//  startp during UNPACK word 5, new size=16 -> o_sp_valid low next cycle, then 4 words of new packet.
//  size=0 -> o_err_len pulse, o_rd_ready stays 0; with SP_IF_IN_WORD_SWAP_EN 1-beat word order reversed.

Source files
------------

// File: rtl/sp_if_in_ddr_rx_if.sv
// SP-IF DDR3 receive bus: Avalon-ST read-data beats in, unpacked 32-bit SP words out.
// master = DDR3 read port / SP side, slave = sp_if_in_ddr_rx.
interface sp_if_in_ddr_rx_if;
    logic         i_rd_sop;
    logic         i_rd_eop;
    logic         i_rd_valid;
    logic [127:0] i_rd_data;
    logic         o_rd_ready;
    logic [31:0]  o_sp_data;
    logic         o_sp_valid;
    logic         i_sp_ready;

    modport master (
        output i_rd_sop, i_rd_eop, i_rd_valid, i_rd_data, i_sp_ready,
        input  o_rd_ready, o_sp_data, o_sp_valid
    );

    modport slave (
        input  i_rd_sop, i_rd_eop, i_rd_valid, i_rd_data, i_sp_ready,
        output o_rd_ready, o_sp_data, o_sp_valid
    );
endinterface

// File: rtl/sp_if_in_ddr_rx.sv
// SP-IF DDR3 receive path: buffers one Avalon-ST packet in a beat RAM, then unpacks it to 32-bit words.
// Optional macro SP_IF_IN_WORD_SWAP_EN reverses the word order within each 128-bit beat.
module sp_if_in_ddr_rx #(
    parameter int unsigned RAM_AW = 11
) (
    input  logic             i_clk156m,
    input  logic             i_arst,
    input  logic             i_ddr_rd_startp,
    input  logic [31:0]      i_ddr_size,
    sp_if_in_ddr_rx_if.slave bus,
    output logic             o_sp_done,
    output logic             o_err_len
);
    typedef enum logic [1:0] {IDLE, WAIT_SOP, RECV, UNPACK} state_t;

    localparam logic [31:0] CAP = 32'd1 << RAM_AW;

    state_t       state;
    logic [31:0]  tgt;
    logic [31:0]  n;
    logic [31:0]  beats;
    logic [31:0]  ra;
    logic [31:0]  beat_out;
    logic         rd_ready;
    logic         rd_vld;
    logic         sp_valid;
    logic [31:0]  sp_data;
    logic [1:0]   widx;
    logic [1:0]   q_cnt;

    logic [127:0] ram [0:(1 << RAM_AW) - 1];
    logic [127:0] rd_q;
    logic [127:0] cur_beat;
    logic [127:0] q [2];

    logic [31:0]  t_raw;
    logic         size_unused;
    logic         accept;
    logic         take;
    logic         n_final;
    logic         last;
    logic         wr_en;
    logic         rd_issue;
    logic         word_xfer;
    logic         beat_end;
    logic         last_beat_end;
    logic         cur_avail;
    logic         load_q;
    logic         load_rd;
    logic         push_rd;
    logic [127:0] load_data;

    function automatic logic [31:0] word_sel(input logic [127:0] b, input logic [1:0] k);
        logic [1:0] w;
`ifdef SP_IF_IN_WORD_SWAP_EN
        w = ~k;
`else
        w = k;
`endif
        return b[{w, 5'd0} +: 32];
    endfunction

    assign t_raw       = {4'd0, i_ddr_size[31:4]};
    assign size_unused = ^i_ddr_size[3:0];

    assign accept  = bus.i_rd_valid && rd_ready;
    assign take    = accept && ((state == RECV) || bus.i_rd_sop);
    assign n_final = (n == tgt - 32'd1);
    assign last    = bus.i_rd_eop || n_final;
    assign wr_en   = take && !i_ddr_rd_startp && !i_arst;

    // Reads are issued only while the skid plus the in-flight read leave room for the result.
    assign rd_issue = (state == UNPACK) && !i_ddr_rd_startp && !i_arst && (ra < beats)
                      && (({1'b0, q_cnt} + {2'b00, rd_vld}) < 3'd2);

    assign word_xfer     = sp_valid && bus.i_sp_ready;
    assign beat_end      = word_xfer && (widx == 2'd3);
    assign last_beat_end = beat_end && (beat_out == beats - 32'd1);
    assign cur_avail     = !sp_valid || beat_end;
    assign load_q        = (state == UNPACK) && !i_ddr_rd_startp && cur_avail && (q_cnt != 2'd0);
    assign load_rd       = (state == UNPACK) && !i_ddr_rd_startp && cur_avail && (q_cnt == 2'd0) && rd_vld;
    assign push_rd       = (state == UNPACK) && !i_ddr_rd_startp && rd_vld && !load_rd;
    assign load_data     = load_q ? q[0] : rd_q;

    always_ff @(posedge i_clk156m) begin
        if (wr_en) ram[n[RAM_AW-1:0]] <= bus.i_rd_data;
        if (rd_issue) rd_q <= ram[ra[RAM_AW-1:0]];
    end

    // Skid entries shift on a pop; the push slot is the post-pop occupancy.
    always_ff @(posedge i_clk156m) begin
        if (load_q || load_rd) cur_beat <= load_data;
        if (load_q) q[0] <= q[1];
        if (push_rd) q[q_cnt[0] ^ load_q] <= rd_q;
    end

    always_ff @(posedge i_clk156m) begin
        if (i_arst) begin
            state     <= IDLE;
            tgt       <= '0;
            n         <= '0;
            beats     <= '0;
            ra        <= '0;
            beat_out  <= '0;
            rd_ready  <= 1'b0;
            rd_vld    <= 1'b0;
            sp_valid  <= 1'b0;
            sp_data   <= '0;
            widx      <= '0;
            q_cnt     <= '0;
            o_sp_done <= 1'b0;
            o_err_len <= 1'b0;
        end else begin
            o_sp_done <= 1'b0;
            o_err_len <= 1'b0;
            if (i_ddr_rd_startp) begin
                n        <= '0;
                ra       <= '0;
                beat_out <= '0;
                rd_vld   <= 1'b0;
                sp_valid <= 1'b0;
                widx     <= '0;
                q_cnt    <= '0;
                if (t_raw == '0) begin
                    state     <= IDLE;
                    rd_ready  <= 1'b0;
                    o_err_len <= 1'b1;
                end else begin
                    state     <= WAIT_SOP;
                    rd_ready  <= 1'b1;
                    tgt       <= (t_raw > CAP) ? CAP : t_raw;
                    o_err_len <= (t_raw > CAP);
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        rd_ready <= 1'b0;
                    end
                    WAIT_SOP, RECV: begin
                        if (accept) begin
                            if (!take) begin
                                o_err_len <= 1'b1;
                            end else begin
                                n <= n + 32'd1;
                                if (last) begin
                                    state     <= UNPACK;
                                    rd_ready  <= 1'b0;
                                    beats     <= n + 32'd1;
                                    ra        <= '0;
                                    beat_out  <= '0;
                                    q_cnt     <= '0;
                                    rd_vld    <= 1'b0;
                                    o_err_len <= (bus.i_rd_eop != n_final)
                                                 || ((state == RECV) && bus.i_rd_sop);
                                end else begin
                                    state     <= RECV;
                                    o_err_len <= (state == RECV) && bus.i_rd_sop;
                                end
                            end
                        end
                    end
                    UNPACK: begin
                        rd_vld <= rd_issue;
                        if (rd_issue) ra <= ra + 32'd1;
                        q_cnt <= q_cnt - {1'b0, load_q} + {1'b0, push_rd};
                        if (beat_end) beat_out <= beat_out + 32'd1;
                        if (last_beat_end) begin
                            o_sp_done <= 1'b1;
                            state     <= IDLE;
                            sp_valid  <= 1'b0;
                        end else if (load_q || load_rd) begin
                            sp_valid <= 1'b1;
                            widx     <= '0;
                            sp_data  <= word_sel(load_data, 2'd0);
                        end else if (beat_end) begin
                            sp_valid <= 1'b0;
                        end else if (word_xfer) begin
                            widx    <= widx + 2'd1;
                            sp_data <= word_sel(cur_beat, widx + 2'd1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_rd_ready = rd_ready;
    assign bus.o_sp_valid = sp_valid;
    assign bus.o_sp_data  = sp_data;
endmodule

// File: tb/tb_sp_if_in_ddr_rx.sv
// Directed self-checking bench for sp_if_in_ddr_rx; expected words come from a fixed per-beat data pattern.
module tb_sp_if_in_ddr_rx;
    logic        clk = 1'b0;
    logic        arst;
    logic        startp;
    logic [31:0] size;
    logic        done;
    logic        err;

    int          vectors = 0;
    int          miscompares = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] got [$];
    bit          tog = 1'b0;
    bit          stab_en = 1'b0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [31:0] pd = '0;

    always #5 clk = ~clk;

    sp_if_in_ddr_rx_if bus ();

    sp_if_in_ddr_rx #(.RAM_AW(11)) dut (
        .i_clk156m       (clk),
        .i_arst          (arst),
        .i_ddr_rd_startp (startp),
        .i_ddr_size      (size),
        .bus             (bus),
        .o_sp_done       (done),
        .o_err_len       (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wpat(input int pkt, input int bt, input int w);
        return {8'hA0 + 8'(pkt), 8'(bt), 8'h5A, 8'(w)};
    endfunction

    function automatic logic [31:0] exp_word(input int pkt, input int bt, input int k);
`ifdef SP_IF_IN_WORD_SWAP_EN
        return wpat(pkt, bt, 3 - k);
`else
        return wpat(pkt, bt, k);
`endif
    endfunction

    function automatic logic [127:0] beat(input int pkt, input int bt);
        logic [127:0] b;
        b = '0;
        for (int w = 0; w < 4; w++) b[32*w +: 32] = wpat(pkt, bt, w);
        return b;
    endfunction

    // Sample at the falling edge, then return 2ns after the next rising edge for driving.
    task automatic tick();
        @(negedge clk);
        if (stab_en && pv && !pr) begin
            chk("hold_valid", {31'b0, bus.o_sp_valid}, 32'd1);
            chk("hold_data", bus.o_sp_data, pd);
        end
        pv = bus.o_sp_valid;
        pr = bus.i_sp_ready;
        pd = bus.o_sp_data;
        if (bus.o_sp_valid && bus.i_sp_ready) got.push_back(bus.o_sp_data);
        if (done) done_cnt++;
        if (err) err_cnt++;
        @(posedge clk);
        #2;
        if (tog) bus.i_sp_ready = ~bus.i_sp_ready;
    endtask

    task automatic start(input logic [31:0] sz);
        size = sz;
        startp = 1'b1;
        tick();
        startp = 1'b0;
        got.delete();
        done_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic send(input int pkt, input int bt, input logic sop, input logic eop);
        chk($sformatf("rd_ready_p%0d_b%0d", pkt, bt), {31'b0, bus.o_rd_ready}, 32'd1);
        bus.i_rd_valid = 1'b1;
        bus.i_rd_sop   = sop;
        bus.i_rd_eop   = eop;
        bus.i_rd_data  = beat(pkt, bt);
        tick();
        bus.i_rd_valid = 1'b0;
        bus.i_rd_sop   = 1'b0;
        bus.i_rd_eop   = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < maxc && done_cnt == d0; i++) tick();
        chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
        tick();
        tick();
        chk("done_once", 32'(done_cnt), 32'(d0 + 1));
    endtask

    task automatic chk_words(input int pkt, input int first_bt, input int nbeats);
        chk($sformatf("word_count_p%0d", pkt), 32'(got.size()), 32'(nbeats * 4));
        for (int i = 0; i < nbeats * 4 && i < got.size(); i++)
            chk($sformatf("word_p%0d_%0d", pkt, i), got[i], exp_word(pkt, first_bt + i / 4, i % 4));
    endtask

    initial begin
        arst = 1'b1;
        startp = 1'b0;
        size = '0;
        bus.i_rd_valid = 1'b0;
        bus.i_rd_sop = 1'b0;
        bus.i_rd_eop = 1'b0;
        bus.i_rd_data = '0;
        bus.i_sp_ready = 1'b1;
        repeat (3) tick();
        chk("rst_rd_ready", {31'b0, bus.o_rd_ready}, 32'd0);
        chk("rst_sp_valid", {31'b0, bus.o_sp_valid}, 32'd0);
        chk("rst_sp_data", bus.o_sp_data, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        arst = 1'b0;
        tick();

        // 4-beat packet, SP always ready, with first-word latency
        start(32'd64);
        for (int b = 0; b < 4; b++) send(1, b, b == 0, b == 3);
        chk("lat_e0_valid", {31'b0, bus.o_sp_valid}, 32'd0);
        tick();
        chk("lat_e1_valid", {31'b0, bus.o_sp_valid}, 32'd0);
        tick();
        chk("lat_e2_valid", {31'b0, bus.o_sp_valid}, 32'd1);
        chk("lat_e2_data", bus.o_sp_data, exp_word(1, 0, 0));
        wait_done(60);
        chk_words(1, 0, 4);
        chk("s1_err", 32'(err_cnt), 32'd0);
        chk("s1_rd_ready", {31'b0, bus.o_rd_ready}, 32'd0);

        // SP ready toggling every cycle
        start(32'd64);
        tog = 1'b1;
        stab_en = 1'b1;
        for (int b = 0; b < 4; b++) send(2, b, b == 0, b == 3);
        wait_done(100);
        tog = 1'b0;
        stab_en = 1'b0;
        bus.i_sp_ready = 1'b1;
        chk_words(2, 0, 4);
        chk("s2_err", 32'(err_cnt), 32'd0);

        // early eop: 8 beats expected, eop on beat 3
        start(32'd128);
        for (int b = 0; b < 4; b++) send(3, b, b == 0, b == 3);
        wait_done(60);
        chk("s3_err", 32'(err_cnt), 32'd1);
        chk_words(3, 0, 4);

        // two beats without sop are discarded
        start(32'd48);
        send(4, 0, 1'b0, 1'b0);
        send(4, 1, 1'b0, 1'b0);
        send(4, 2, 1'b1, 1'b0);
        send(4, 3, 1'b0, 1'b0);
        send(4, 4, 1'b0, 1'b1);
        wait_done(60);
        chk("s4_err", 32'(err_cnt), 32'd2);
        chk_words(4, 2, 3);

        // abort during unpack at word 5, restart with a 1-beat packet
        start(32'd64);
        for (int b = 0; b < 4; b++) send(5, b, b == 0, b == 3);
        for (int i = 0; i < 50 && got.size() < 5; i++) tick();
        chk("s5_pre_words", 32'(got.size()), 32'd5);
        chk("s5_word5", bus.o_sp_data, exp_word(5, 1, 1));
        size = 32'd16;
        startp = 1'b1;
        tick();
        startp = 1'b0;
        chk("s5_abort_valid", {31'b0, bus.o_sp_valid}, 32'd0);
        chk("s5_no_done", 32'(done_cnt), 32'd0);
        got.delete();
        err_cnt = 0;
        send(6, 0, 1'b1, 1'b1);
        wait_done(40);
        chk_words(6, 0, 1);
        chk("s5_err", 32'(err_cnt), 32'd0);

        // zero size: error pulse, stays idle
        size = 32'd0;
        startp = 1'b1;
        tick();
        startp = 1'b0;
        chk("s6_err_pulse", {31'b0, err}, 32'd1);
        chk("s6_rd_ready", {31'b0, bus.o_rd_ready}, 32'd0);
        tick();
        chk("s6_err_clear", {31'b0, err}, 32'd0);
        chk("s6_rd_ready2", {31'b0, bus.o_rd_ready}, 32'd0);

        // oversize clamps and continues; single sop+eop beat is then early
        start(32'h0000_8010);
        send(7, 0, 1'b1, 1'b1);
        wait_done(40);
        chk("s7_err", 32'(err_cnt), 32'd2);
        chk_words(7, 0, 1);

        // one target beat arriving without eop
        start(32'd16);
        send(8, 0, 1'b1, 1'b0);
        wait_done(40);
        chk("s8_err", 32'(err_cnt), 32'd1);
        chk_words(8, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
